cas_byte_feeder: RTL and testbench
==================================

// Module: cas_byte_feeder
// PURPOSE
//  Upstream stage of the cassette FSK square-wave generator. Buffers .CAS image bytes arriving
//  from the loader/ioctl path in a small FIFO. Hands them one at a time to the generator via its
//  start/din/done handshake, gated by the cassette motor relay. Tracks end-of-file, underrun,
//  overflow and a played-byte count for the OSD/status path.
// PARAMETERS
//  DEPTH_LOG2  4      FIFO depth = 2**DEPTH_LOG2 bytes
//  ACK_TO      15     clocks to wait for gen_done to fall after gen_start before re-issuing
//  LEADER_LEN  128    0x55 leader bytes inserted per motor-on (CAS_LEADER_EN only)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  motor       in   1   cassette relay; 1 = play
//  wr          in   1   loader byte strobe, one byte per high cycle
//  wdata       in   8   loader byte
//  load_done   in   1   level; loader has written the last byte of the image
//  wr_ready    out  1   FIFO not full
//  gen_start   out  1   one-cycle start pulse to generator
//  gen_din     out  8   byte to generator; stable from gen_start until gen_done rises
//  gen_done    in   1   generator done level (low while shifting bits)
//  playing     out  1   a byte is in flight (ISSUE/WAIT_LO/WAIT_HI)
//  eof         out  1   sticky; FIFO drained with load_done high
//  underrun    out  1   sticky; FIFO empty, motor on, load_done low
//  overflow    out  1   sticky; wr while full (byte dropped)
//  byte_count  out  24  bytes completed (gen_done rising seen), wraps at 2**24
// BEHAVIOUR
//  Reset: all outputs 0 except wr_ready=1. FIFO flushed, FSM -> IDLE.
//  FIFO: registered read; a write is accepted iff not full at the start of that cycle, even if a
//   pop occurs in the same cycle. Write+pop on empty: write accepted, pop suppressed.
//  FSM states: IDLE, FETCH, ISSUE, WAIT_LO, WAIT_HI, DONE_EOF (+LEADER with macro).
//   IDLE: motor=1 & !empty -> pop, FETCH. motor=1 & empty & load_done -> DONE_EOF, eof<=1.
//         motor=1 & empty & !load_done -> stay, underrun<=1.
//   FETCH: gen_din<=FIFO head -> ISSUE.
//   ISSUE: gen_start=1 for exactly 1 clk; timeout counter cleared -> WAIT_LO.
//   WAIT_LO: gen_done=0 -> WAIT_HI. Counter reaches ACK_TO -> ISSUE again (same gen_din),
//     unlimited retries.
//   WAIT_HI: gen_done=1 -> byte_count+1, -> IDLE. Motor is ignored here; an in-flight byte
//     always completes.
//   DONE_EOF: holds until reset, or until a wr is accepted (eof<=0, -> IDLE).
//  Latency: motor sampled high in IDLE with FIFO non-empty -> gen_start high on the 2nd
//   following clk edge.
//  Motor falling edge: finish current byte, then park in IDLE. Motor rising edge clears underrun.
//  overflow clears only on reset.
//  Reset mid-byte: gen_start drops; the generator (no reset) may finish its byte, and this block
//   does not wait for it.
//  wr_ready = !full, registered with FIFO pointers.
// CONFIGURATION
//  CAS_LEADER_EN defined: on each motor rising edge (FSM in IDLE), emit LEADER_LEN bytes of 8'h55
//   through ISSUE/WAIT_LO/WAIT_HI before any FIFO byte. Leader bytes do not count in byte_count.
//   Motor drop during leader aborts the remaining leader after the current byte.
//  Undefined: no LEADER state; the image supplies its own leader.
// STRUCTURE
//  cas_pkg: FSM state encodings, LEADER_BYTE=8'h55, CNT_W=24.
//  Sub-module cas_fifo (sync FIFO, DEPTH_LOG2, registered read, full/empty) instantiated once.
//  FSM, timeout counter and status flags live in this module.
// TESTING
//  1. Write 3 bytes A5,00,FF, motor=1, model gen_done (falls 2 clk after start, rises 40 clk later)
//     -> gen_din A5,00,FF in order, 3 start pulses, byte_count=3.
//  2. Then load_done=1 with FIFO empty -> eof=1, playing=0; one more wr -> eof=0, byte issued.
//  3. Write 2**DEPTH_LOG2+1 bytes, motor=0 -> wr_ready=0 after 16, overflow=1, 17th byte never played.
//  4. Model never drops gen_done -> gen_start re-pulses every ACK_TO+1 clk with unchanged gen_din.
//  5. motor=0 mid-byte -> WAIT_HI completes, no further start; motor=1 -> resumes next byte.
//     Empty FIFO with load_done=0 -> underrun=1.
//  6. CAS_LEADER_EN, LEADER_LEN=4, motor 0->1 -> four 8'h55 before first FIFO byte, byte_count
//     excludes them. reset asserted in WAIT_HI -> gen_start=0, FIFO empty next cycle.

Source files
------------

// File: rtl/cas_pkg.sv
// Shared encodings for the cassette byte feeder: FSM states, leader byte, counter width.
package cas_pkg;

    typedef logic [2:0] cas_state_t;

    // IDLE wait motor/data | FETCH latch head | ISSUE start pulse | WAIT_LO ack | WAIT_HI byte end | DONE_EOF drained | LEADER 0x55 byte
    localparam cas_state_t ST_IDLE     = 3'd0;
    localparam cas_state_t ST_FETCH    = 3'd1;
    localparam cas_state_t ST_ISSUE    = 3'd2;
    localparam cas_state_t ST_WAIT_LO  = 3'd3;
    localparam cas_state_t ST_WAIT_HI  = 3'd4;
    localparam cas_state_t ST_DONE_EOF = 3'd5;
    localparam cas_state_t ST_LEADER   = 3'd6;

    localparam logic [7:0] LEADER_BYTE = 8'h55;
    localparam int         CNT_W       = 24;

    function automatic logic is_busy(input cas_state_t s);
        return (s == ST_ISSUE) || (s == ST_WAIT_LO) || (s == ST_WAIT_HI);
    endfunction

endpackage

// File: rtl/cas_fifo.sv
// Synchronous byte FIFO with registered read data and full/empty/overflow flags.
module cas_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       ovf_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            rdata_q;
    logic                  wr_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign wr_ok   = wr_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign ovf_o   = wr_i && full_o;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rdata_q <= mem_q[rptr_q];
                rptr_q  <= rptr_q + 1'b1;
            end
            if (wr_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!wr_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cas_byte_feeder.sv
// Feeds buffered .CAS bytes to the FSK generator under motor control, with eof/underrun/overflow status.
// Optional CAS_LEADER_EN inserts LEADER_LEN bytes of 0x55 after each motor start.
module cas_byte_feeder
    import cas_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ACK_TO     = 15
`ifdef CAS_LEADER_EN
    ,
    parameter int LEADER_LEN = 128
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor,
    input  logic             wr,
    input  logic [7:0]       wdata,
    input  logic             load_done,
    output logic             wr_ready,
    output logic             gen_start,
    output logic [7:0]       gen_din,
    input  logic             gen_done,
    output logic             playing,
    output logic             eof,
    output logic             underrun,
    output logic             overflow,
    output logic [CNT_W-1:0] byte_count
);

    localparam int TMO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TO - 1);

    cas_state_t       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       din_q, din_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eof_q, eof_d, und_q, und_d, ovf_q, ovf_d;
    logic             motor_q, motor_rise;
    logic             pop, fifo_full, fifo_empty, fifo_ovf;
    logic [7:0]       fifo_rdata;
`ifdef CAS_LEADER_EN
    localparam int LEAD_W = $clog2(LEADER_LEN + 1);
    logic [LEAD_W-1:0] lead_q, lead_d;
    logic              in_lead_q, in_lead_d;
`endif

    cas_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .wr_i    (wr),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ovf_o   (fifo_ovf)
    );

    assign motor_rise = motor && !motor_q;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        eof_d   = eof_q;
        und_d   = und_q;
        ovf_d   = ovf_q | fifo_ovf;
        pop     = 1'b0;
`ifdef CAS_LEADER_EN
        lead_d    = lead_q;
        in_lead_d = in_lead_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef CAS_LEADER_EN
                if (motor_rise && (LEADER_LEN > 0)) begin
                    lead_d  = LEAD_W'(LEADER_LEN);
                    state_d = ST_LEADER;
                end else
`endif
                if (motor) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_FETCH;
                    end else if (load_done) begin
                        eof_d   = 1'b1;
                        state_d = ST_DONE_EOF;
                    end else begin
                        und_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                din_d   = fifo_rdata;
                state_d = ST_ISSUE;
            end
`ifdef CAS_LEADER_EN
            ST_LEADER: begin
                din_d     = LEADER_BYTE;
                lead_d    = lead_q - LEAD_W'(1);
                in_lead_d = 1'b1;
                state_d   = ST_ISSUE;
            end
`endif
            ST_ISSUE: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // Generator never acknowledged: re-pulse start with the same byte.
                if (!gen_done) begin
                    state_d = ST_WAIT_HI;
                end else if (tmo_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_WAIT_HI: begin
                if (gen_done) begin
`ifdef CAS_LEADER_EN
                    if (in_lead_q) begin
                        if (motor && (lead_q != '0)) begin
                            state_d = ST_LEADER;
                        end else begin
                            in_lead_d = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end else
`endif
                    begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE_EOF: begin
                if (wr && !fifo_full) begin
                    eof_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (motor_rise) begin
            und_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            eof_q   <= 1'b0;
            und_q   <= 1'b0;
            ovf_q   <= 1'b0;
            motor_q <= 1'b0;
`ifdef CAS_LEADER_EN
            lead_q    <= '0;
            in_lead_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            eof_q   <= eof_d;
            und_q   <= und_d;
            ovf_q   <= ovf_d;
            motor_q <= motor;
`ifdef CAS_LEADER_EN
            lead_q    <= lead_d;
            in_lead_q <= in_lead_d;
`endif
        end
    end

    assign wr_ready   = !fifo_full;
    assign gen_start  = (state_q == ST_ISSUE);
    assign gen_din    = din_q;
    assign playing    = is_busy(state_q);
    assign eof        = eof_q;
    assign underrun   = und_q;
    assign overflow   = ovf_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_cas_byte_feeder.sv
// Directed bench for cas_byte_feeder with a behavioural FSK generator model on gen_start/gen_done.
module tb_cas_byte_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        motor = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        load_done = 1'b0;
    logic        wr_ready, gen_start, playing, eof, underrun, overflow;
    logic [7:0]  gen_din;
    logic        gen_done = 1'b1;
    logic [23:0] byte_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cas_byte_feeder #(
        .DEPTH_LOG2(4),
        .ACK_TO    (15)
`ifdef CAS_LEADER_EN
        ,
        .LEADER_LEN(4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .motor      (motor),
        .wr         (wr),
        .wdata      (wdata),
        .load_done  (load_done),
        .wr_ready   (wr_ready),
        .gen_start  (gen_start),
        .gen_din    (gen_din),
        .gen_done   (gen_done),
        .playing    (playing),
        .eof        (eof),
        .underrun   (underrun),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    // Generator model: gen_done falls 2 clk after a start, rises 40 clk later; gmode=1 never acks.
    int         nstarts = 0;
    logic [7:0] slog[$];
    int         scyc[$];
    int         mcyc = 0;
    int         gstate = 0;
    int         gcnt = 0;
    int         gmode = 0;

    always @(negedge clk) begin
        mcyc++;
        if (gen_start) begin
            nstarts++;
            slog.push_back(gen_din);
            scyc.push_back(mcyc);
        end
        case (gstate)
            0: if (gen_start && gmode == 0) begin
                gstate = 1;
                gcnt   = 2;
            end
            1: begin
                gcnt--;
                if (gcnt == 0) begin
                    gen_done = 1'b0;
                    gstate   = 2;
                    gcnt     = 40;
                end
            end
            default: begin
                gcnt--;
                if (gcnt == 0) begin
                    gen_done = 1'b1;
                    gstate   = 0;
                end
            end
        endcase
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr    = 1'b1;
        wdata = b;
        step(1);
        wr    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        tests++; if (gen_start !== 1'b0) begin fails++; $display("FAIL reset_gen_start: got %b want 0", gen_start); end
        tests++; if (playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %b want 0", playing); end
        tests++; if ({eof, underrun, overflow} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {eof, underrun, overflow}); end
        tests++; if (byte_count !== 24'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        tests++; if (gen_din !== 8'h00) begin fails++; $display("FAIL reset_din: got %h want 00", gen_din); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        logic [7:0] v [3];
        int s0;
        v  = '{8'hA5, 8'h00, 8'hFF};
        s0 = nstarts;
        for (int i = 0; i < 3; i++) write_byte(v[i]);
        motor = 1'b1;
        step(2);
        tests++; if (gen_start !== 1'b1) begin fails++; $display("FAIL basic_latency: gen_start got %b want 1", gen_start); end
        tests++; if (gen_din !== 8'hA5) begin fails++; $display("FAIL basic_first_din: got %h want a5", gen_din); end
        for (int i = 0; i < 400 && byte_count != 24'd3; i++) step(1);
        tests++; if (byte_count !== 24'd3) begin fails++; $display("FAIL basic_count: got %0d want 3", byte_count); end
        tests++; if (nstarts - s0 != 3) begin fails++; $display("FAIL basic_starts: got %0d want 3", nstarts - s0); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (slog[s0 + i] !== v[i]) begin fails++; $display("FAIL basic_order[%0d]: got %h want %h", i, slog[s0 + i], v[i]); end
        end
        step(2);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL basic_underrun: got %b want 1", underrun); end
    endtask

    task automatic test_eof();
        load_done = 1'b1;
        step(3);
        tests++; if (eof !== 1'b1) begin fails++; $display("FAIL eof_set: got %b want 1", eof); end
        tests++; if (playing !== 1'b0) begin fails++; $display("FAIL eof_playing: got %b want 0", playing); end
        write_byte(8'h3C);
        tests++; if (eof !== 1'b0) begin fails++; $display("FAIL eof_clear_on_wr: got %b want 0", eof); end
        for (int i = 0; i < 200 && byte_count != 24'd4; i++) step(1);
        tests++; if (byte_count !== 24'd4) begin fails++; $display("FAIL eof_extra_count: got %0d want 4", byte_count); end
        tests++; if (slog[slog.size() - 1] !== 8'h3C) begin fails++; $display("FAIL eof_extra_din: got %h want 3c", slog[slog.size() - 1]); end
        step(3);
        tests++; if (eof !== 1'b1) begin fails++; $display("FAIL eof_reset_again: got %b want 1", eof); end
        motor     = 1'b0;
        load_done = 1'b0;
        step(1);
    endtask

    task automatic test_overflow();
        int s0;
        s0 = nstarts;
        for (int i = 0; i < 17; i++) begin
            write_byte(8'(16 + i));
            if (i == 15) begin
                tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL ovf_full_after16: wr_ready got %b want 0", wr_ready); end
            end
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        motor = 1'b1;
        for (int i = 0; i < 1200 && byte_count != 24'd20; i++) step(1);
        step(60);
        tests++; if (byte_count !== 24'd20) begin fails++; $display("FAIL ovf_count: got %0d want 20", byte_count); end
        tests++; if (nstarts - s0 != 16) begin fails++; $display("FAIL ovf_starts: got %0d want 16", nstarts - s0); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (slog[s0 + i] !== 8'(16 + i)) begin fails++; $display("FAIL ovf_order[%0d]: got %h want %h", i, slog[s0 + i], 8'(16 + i)); end
        end
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ovf_underrun: got %b want 1", underrun); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_timeout();
        int s0;
        gmode = 1;
        s0    = nstarts;
        write_byte(8'h77);
        step(58);
        tests++; if (nstarts - s0 < 3) begin fails++; $display("FAIL tmo_retries: got %0d starts want >=3", nstarts - s0); end
        for (int i = 0; i < 2; i++) begin
            tests++; if (scyc[s0 + i + 1] - scyc[s0 + i] != 16) begin fails++; $display("FAIL tmo_period[%0d]: got %0d want 16", i, scyc[s0 + i + 1] - scyc[s0 + i]); end
        end
        for (int i = 0; i < 3; i++) begin
            tests++; if (slog[s0 + i] !== 8'h77) begin fails++; $display("FAIL tmo_din[%0d]: got %h want 77", i, slog[s0 + i]); end
        end
        gmode = 0;
        for (int i = 0; i < 120 && byte_count != 24'd21; i++) step(1);
        tests++; if (byte_count !== 24'd21) begin fails++; $display("FAIL tmo_complete: got %0d want 21", byte_count); end
    endtask

    task automatic test_motor_drop();
        int          s0;
        logic [23:0] c0;
        motor = 1'b0;
        step(1);
        write_byte(8'h81);
        write_byte(8'h82);
        c0    = byte_count;
        s0    = nstarts;
        motor = 1'b1;
        for (int i = 0; i < 60 && !(playing && !gen_done); i++) step(1);
        motor = 1'b0;
        for (int i = 0; i < 100 && byte_count != c0 + 24'd1; i++) step(1);
        step(60);
        tests++; if (byte_count !== c0 + 24'd1) begin fails++; $display("FAIL drop_count: got %0d want %0d", byte_count, c0 + 24'd1); end
        tests++; if (nstarts - s0 != 1) begin fails++; $display("FAIL drop_no_start: got %0d starts want 1", nstarts - s0); end
        tests++; if (playing !== 1'b0) begin fails++; $display("FAIL drop_parked: playing got %b want 0", playing); end
        tests++; if (slog[s0] !== 8'h81) begin fails++; $display("FAIL drop_din: got %h want 81", slog[s0]); end
        motor = 1'b1;
        step(1);
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rise_clears_underrun: got %b want 0", underrun); end
        for (int i = 0; i < 150 && byte_count != c0 + 24'd2; i++) step(1);
        tests++; if (slog[s0 + 1] !== 8'h82) begin fails++; $display("FAIL resume_din: got %h want 82", slog[s0 + 1]); end
        step(3);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL resume_underrun: got %b want 1", underrun); end
    endtask

    task automatic test_reset_mid_byte();
        int s0;
        int bad;
        motor = 1'b0;
        step(1);
        write_byte(8'h99);
        write_byte(8'h9A);
        write_byte(8'h9B);
        motor = 1'b1;
        for (int i = 0; i < 60 && !(playing && !gen_done); i++) step(1);
        reset = 1'b1;
        step(1);
        tests++; if (gen_start !== 1'b0) begin fails++; $display("FAIL rst_mid_start: got %b want 0", gen_start); end
        tests++; if (playing !== 1'b0) begin fails++; $display("FAIL rst_mid_playing: got %b want 0", playing); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_wr_ready: got %b want 1", wr_ready); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
        tests++; if (byte_count !== 24'd0) begin fails++; $display("FAIL rst_mid_count: got %0d want 0", byte_count); end
        reset     = 1'b0;
        load_done = 1'b1;
        s0        = nstarts;
        for (int i = 0; i < 400 && eof != 1'b1; i++) step(1);
        tests++; if (eof !== 1'b1) begin fails++; $display("FAIL rst_mid_fifo_empty: eof got %b want 1", eof); end
        bad = 0;
        for (int i = s0; i < nstarts; i++) if (slog[i] !== 8'h55) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rst_mid_flushed: got %0d stale bytes want 0", bad); end
        tests++; if (byte_count !== 24'd0) begin fails++; $display("FAIL rst_mid_count2: got %0d want 0", byte_count); end
        load_done = 1'b0;
        motor     = 1'b0;
        step(1);
    endtask

`ifdef CAS_LEADER_EN
    task automatic test_leader();
        int         s0;
        logic [7:0] exp_b;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 100 && !(gstate == 0 && gen_done); i++) step(1);
        s0 = nstarts;
        write_byte(8'hC3);
        motor = 1'b1;
        for (int i = 0; i < 400 && byte_count != 24'd1; i++) step(1);
        tests++; if (byte_count !== 24'd1) begin fails++; $display("FAIL leader_count: got %0d want 1", byte_count); end
        tests++; if (nstarts - s0 != 5) begin fails++; $display("FAIL leader_starts: got %0d want 5", nstarts - s0); end
        for (int i = 0; i < 5; i++) begin
            exp_b = (i < 4) ? 8'h55 : 8'hC3;
            tests++; if (slog[s0 + i] !== exp_b) begin fails++; $display("FAIL leader_seq[%0d]: got %h want %h", i, slog[s0 + i], exp_b); end
        end
        motor = 1'b0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_eof();
        test_overflow();
        test_timeout();
        test_motor_drop();
        test_reset_mid_byte();
`ifdef CAS_LEADER_EN
        test_leader();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
